// File: rtl/gray_counter_if.sv
// Counter control/status bundle between the driver and gray_counter.
// master drives the controls, slave (the counter) returns the count.
interface gray_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             ovf;

    modport master (
        output en, up, load, load_bin,
        input  bin, gray, ovf
    );

    modport slave (
        input  en, up, load, load_bin,
        output bin, gray, ovf
    );
endinterface

// File: rtl/gray_counter.sv
// Up/down Gray counter with binary load; GRAY_COUNTER_SAT_EN selects
// saturation at the range limits instead of modular wrap.
module gray_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned INIT  = 0
) (
    input  logic           clk,
    input  logic           resetn,
    gray_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("gray_counter: WIDTH must be 2..32");
    end

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic             at_max, at_min;

    assign at_max = (bin_q == '1);
    assign at_min = (bin_q == '0);

    always_comb begin
        bin_d = bin_q;
        ovf_d = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_bin;
        end else if (bus.en && bus.up) begin
            ovf_d = at_max;
`ifdef GRAY_COUNTER_SAT_EN
            if (!at_max) bin_d = bin_q + ONE;
`else
            bin_d = bin_q + ONE;
`endif
        end else if (bus.en) begin
            ovf_d = at_min;
`ifdef GRAY_COUNTER_SAT_EN
            if (!at_min) bin_d = bin_q - ONE;
`else
            bin_d = bin_q - ONE;
`endif
        end
        // Gray is registered from next_bin so bin and gray never skew.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bin_q  <= INIT_BIN;
            gray_q <= INIT_GRAY;
            ovf_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.bin  = bin_q;
    assign bus.gray = gray_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_gray_counter.sv
// Randomized and directed checks of gray_counter against a value-level
// model using a reflected-code Gray table.
module tb_gray_counter;
    localparam int W   = 4;
    localparam int N   = 1 << W;
    localparam int MAX = N - 1;

    logic clk;
    logic resetn;
    gray_counter_if #(.WIDTH(W)) ifc ();

    gray_counter #(.WIDTH(W), .INIT(0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int gtab [N];
    int m_bin;
    int m_ovf;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_gray();
        int size;
        gtab[0] = 0;
        size = 1;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < size; i++)
                gtab[size + i] = gtab[size - 1 - i] | (1 << k);
            size = size * 2;
        end
    endtask

    task automatic model(input bit l, input int lb,
                         input bit e, input bit u);
        m_ovf = 0;
        if (l) begin
            m_bin = lb;
        end else if (e && u) begin
            if (m_bin == MAX) begin
                m_ovf = 1;
`ifndef GRAY_COUNTER_SAT_EN
                m_bin = 0;
`endif
            end else m_bin = m_bin + 1;
        end else if (e) begin
            if (m_bin == 0) begin
                m_ovf = 1;
`ifndef GRAY_COUNTER_SAT_EN
                m_bin = MAX;
`endif
            end else m_bin = m_bin - 1;
        end
    endtask

    task automatic compare(input string tag, input bit stepped,
                           input logic [W-1:0] pb,
                           input logic [W-1:0] pg);
        chk({tag, ".bin"},  32'(ifc.bin),  32'(m_bin));
        chk({tag, ".gray"}, 32'(ifc.gray), 32'(gtab[m_bin]));
        chk({tag, ".ovf"},  32'(ifc.ovf),  32'(m_ovf));
        if (stepped && pb != ifc.bin)
            chk({tag, ".onebit"}, 32'($countones(ifc.gray ^ pg)), 32'd1);
    endtask

    task automatic cyc(input string tag, input bit l, input int lb,
                       input bit e, input bit u);
        logic [W-1:0] pb, pg;
        @(negedge clk);
        ifc.load     = l;
        ifc.load_bin = W'(lb);
        ifc.en       = e;
        ifc.up       = u;
        pb = ifc.bin;
        pg = ifc.gray;
        @(posedge clk);
        model(l, lb, e, u);
        #1;
        compare(tag, e && !l, pb, pg);
    endtask

    initial begin
        build_gray();
        ifc.load = 0; ifc.load_bin = '0; ifc.en = 0; ifc.up = 1;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        m_bin = 0; m_ovf = 0;
        chk("rst.bin",  32'(ifc.bin),  32'd0);
        chk("rst.gray", 32'(ifc.gray), 32'd0);
        chk("rst.ovf",  32'(ifc.ovf),  32'd0);
        ifc.en = 1;
        @(posedge clk); #1;
        chk("rst.hold", 32'(ifc.bin), 32'd0);
        @(negedge clk);
        ifc.en = 0;
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) cyc("up9", 0, 0, 1, 1);
        chk("up9.bin",  32'(ifc.bin),  32'b1001);
        chk("up9.gray", 32'(ifc.gray), 32'b1101);

        cyc("ldpri", 1, 5, 1, 1);
        chk("ldpri.bin",  32'(ifc.bin),  32'b0101);
        chk("ldpri.gray", 32'(ifc.gray), 32'b0111);
        chk("ldpri.ovf",  32'(ifc.ovf),  32'd0);

        cyc("ld15", 1, 15, 0, 0);
        cyc("wrapup", 0, 0, 1, 1);
`ifdef GRAY_COUNTER_SAT_EN
        chk("satup.bin",  32'(ifc.bin),  32'b1111);
        chk("satup.gray", 32'(ifc.gray), 32'b1000);
        cyc("satup2", 0, 0, 1, 1);
`else
        chk("wrapup.bin",  32'(ifc.bin),  32'b0000);
        chk("wrapup.gray", 32'(ifc.gray), 32'b0000);
`endif
        chk("wrapup.ovf", 32'(ifc.ovf), 32'd1);
        cyc("idle", 0, 0, 0, 1);
        chk("idle.ovf", 32'(ifc.ovf), 32'd0);

        cyc("ld0", 1, 0, 0, 0);
        cyc("wrapdn", 0, 0, 1, 0);
`ifdef GRAY_COUNTER_SAT_EN
        chk("satdn.bin", 32'(ifc.bin), 32'b0000);
`else
        chk("wrapdn.bin",  32'(ifc.bin),  32'b1111);
        chk("wrapdn.gray", 32'(ifc.gray), 32'b1000);
`endif
        chk("wrapdn.ovf", 32'(ifc.ovf), 32'd1);
        cyc("revup", 0, 0, 1, 1);

        cyc("ld0b", 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc("cnt6", 0, 0, 1, 1);
        chk("cnt6.bin", 32'(ifc.bin), 32'd6);
        #1 resetn = 1'b0;
        #1;
        m_bin = 0; m_ovf = 0;
        chk("arst.bin",  32'(ifc.bin),  32'd0);
        chk("arst.gray", 32'(ifc.gray), 32'd0);
        #4 resetn = 1'b1;
        @(posedge clk);
        model(0, 0, 1, 1);
        #1;
        chk("resume.bin",  32'(ifc.bin), 32'd1);
        compare("resume", 0, '0, '0);

        for (int i = 0; i < 400; i++)
            cyc("rnd", $urandom_range(0, 7) == 0, $urandom_range(0, MAX),
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised synchronous Gray-code counter with up/down stepping, parallel binary load, and registered Gray and binary outputs. It builds on the team's combinational binary-to-Gray decoder by adding state, arbitrary width and direction control. It serves as the position counter for pointer and encoder logic in the lab designs, where only one output bit may change per step.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range is 2..32.
- `INIT`, default 0: binary value loaded at reset; must be below 2^WIDTH.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `resetn`  in  1: reset, asynchronous, active-low.
- `en`  in  1: step enable; one step per cycle while high.
- `up`  in  1: direction; 1 increments, 0 decrements. Sampled only when a step occurs.
- `load`  in  1: parallel load strobe; has priority over `en`.
- `load_bin`  in  WIDTH: binary value to load.
- `bin`  out  WIDTH: registered binary count.
- `gray`  out  WIDTH: registered Gray code of `bin`.
- `ovf`  out  1: registered one-cycle pulse marking a step across the range boundary.

## Operation
- The internal state is the binary register `bin`. `gray` is a separate register written on the same edge with next_bin ^ (next_bin >> 1). It is never derived combinationally from `bin` at the output.
- Reset (`resetn`=0): `bin`=INIT, `gray`=INIT^(INIT>>1), `ovf`=0. All three take these values immediately, with no clock required, and hold them while reset is low.
- Priority per edge: load, then step, then hold.
  - load=1: `bin`=load_bin, `gray`=Gray(load_bin), `ovf`=0. `en` and `up` are ignored.
  - load=0, en=1, up=1: `bin`=bin+1 mod 2^WIDTH. `ovf`=1 if `bin` was all-ones, otherwise 0.
  - load=0, en=1, up=0: `bin`=bin-1 mod 2^WIDTH. `ovf`=1 if `bin` was zero, otherwise 0.
  - load=0, en=0: `bin` and `gray` hold, `ovf`=0.
- `ovf` is high for exactly the one cycle after the boundary step. Back-to-back boundary crossings produce back-to-back pulses.
- Every step, including the wrap step, changes exactly one bit of `gray`. A load may change any number of bits.
- Arithmetic is unsigned and WIDTH bits wide; carry and borrow are discarded apart from driving `ovf`.

## Timing
- Latency: the registered outputs show the effect of a load or step on the edge where it is sampled. `bin` and `gray` are always mutually consistent, with no cycle of skew between them.
- There are no combinational paths from inputs to outputs.
- `resetn` assertion mid-count aborts the step in progress. On deassertion, the first rising edge with `resetn`=1 is treated as a normal cycle.
- Any `up` change between steps takes effect on the next enabled edge. Direction reversal at a boundary follows the rules above. Example: at zero, down wraps to all-ones with `ovf`=1; the following up step returns to zero with `ovf`=1.

## Configuration
- Macro: `GRAY_COUNTER_SAT_EN`.
- Defined:
  - The counter saturates. An up step at all-ones and a down step at zero leave `bin` and `gray` unchanged and pulse `ovf` for one cycle.
  - Each further attempted step beyond the limit pulses `ovf` again.
  - Load and reset behave as in the non-saturating mode.
- Undefined: modular wrap as described in Operation.

## Test plan
- Reset with WIDTH=4, INIT=0: drive `resetn`=0 asynchronously between edges. Outputs go to `bin`=0000, `gray`=0000, `ovf`=0 before the next edge.
- Nine up steps from 0 give `bin`=1001, `gray`=1101. After each edge, check that `gray` differs from its previous value in exactly one bit.
- Assert load with load_bin=0101 and en=1, up=1 in the same cycle. Expect `bin`=0101, `gray`=0111 and `ovf`=0; the load wins over the step.
- Load 1111, then one up step. Without the macro: `bin`=0000, `gray`=0000, `ovf`=1 for one cycle, then 0. With `GRAY_COUNTER_SAT_EN`: `bin`=1111, `gray`=1000, `ovf`=1.
- One down step from 0000. Without the macro: `bin`=1111, `gray`=1000, `ovf`=1. With the macro: `bin` stays 0000 and `ovf`=1.
- With en=1 and up=1 held, count to 0110, then pulse `resetn` low for half a cycle. `bin` returns to 0000 without waiting for an edge. Counting resumes from 0001 on the first edge after release.
